// File: rtl/cond_issue_ctrl.sv
// Issue-stage condition controller: owns NZCV, tracks in-flight flag setters and
// emits a registered execute/annul decision per accepted instruction.
module cond_issue_ctrl #(
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned MAX_PEND = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [3:0]       i_in_cond,
   input  logic             i_in_set_flags,
   input  logic [TAG_W-1:0] i_in_tag,
   output logic             o_ex_valid,
   input  logic             i_ex_ready,
   output logic             o_ex_execute,
   output logic [TAG_W-1:0] o_ex_tag,
   input  logic             i_wb_flags_valid,
   input  logic [3:0]       i_wb_flags,
   input  logic             i_sr_wr_en,
   input  logic [3:0]       i_sr_wr_data,
   output logic [3:0]       o_flags,
   output logic             o_pend_err
);

   localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

   logic [3:0]       r_flags;
   logic [CNT_W-1:0] r_pend;
   logic             r_ex_valid;
   logic             r_ex_execute;
   logic [TAG_W-1:0] r_ex_tag;
   logic             r_pend_err;

   logic [3:0]       w_flags_next;
   logic             w_z, w_c, w_n, w_v;
   logic             w_cond_ok;
   logic             w_dec;
   logic             w_inc;
   logic             w_uncond;
   logic             w_flag_stall;
   logic             w_pend_full;
   logic             w_accept;
   logic [CNT_W-1:0] w_pend_eff;
   logic [CNT_W-1:0] w_pend_next;

   // Direct status-register writes take priority over ALU writeback.
   always_comb begin
      w_flags_next = r_flags;
      if (i_sr_wr_en) begin
         w_flags_next = i_sr_wr_data;
      end else if (i_wb_flags_valid) begin
         w_flags_next = i_wb_flags;
      end
   end

   assign {w_z, w_c, w_n, w_v} = w_flags_next;

   // Evaluated on next-state flags so a same-cycle writeback is bypassed.
   always_comb begin
      w_cond_ok = 1'b0;
      unique case (i_in_cond)
         4'd0:  w_cond_ok = w_z;
         4'd1:  w_cond_ok = ~w_z;
         4'd2:  w_cond_ok = w_c;
         4'd3:  w_cond_ok = ~w_c;
         4'd4:  w_cond_ok = w_n;
         4'd5:  w_cond_ok = ~w_n;
         4'd6:  w_cond_ok = w_v;
         4'd7:  w_cond_ok = ~w_v;
         4'd8:  w_cond_ok = w_c & ~w_z;
         4'd9:  w_cond_ok = ~w_c | w_z;
         4'd10: w_cond_ok = (w_n == w_v);
         4'd11: w_cond_ok = (w_n != w_v);
         4'd12: w_cond_ok = ~w_z & (w_n == w_v);
         4'd13: w_cond_ok = w_z | (w_n != w_v);
         4'd14: w_cond_ok = 1'b1;
         4'd15: w_cond_ok = 1'b0;
         default: w_cond_ok = 1'b0;
      endcase
   end

   assign w_dec        = i_wb_flags_valid & (r_pend != '0);
   assign w_pend_eff   = r_pend - CNT_W'(w_dec);
   assign w_uncond     = &i_in_cond[3:1];
   assign w_flag_stall = ~w_uncond & (w_pend_eff != '0);
   assign w_pend_full  = i_in_set_flags & (w_pend_eff == CNT_W'(MAX_PEND));

   assign o_in_ready = (~r_ex_valid | i_ex_ready) & ~w_flag_stall & ~w_pend_full;

   // Reset dominates, so nothing offered during rst is taken.
   assign w_accept    = i_in_valid & o_in_ready & ~i_rst;
   assign w_inc       = w_accept & i_in_set_flags & w_cond_ok;
   assign w_pend_next = w_pend_eff + CNT_W'(w_inc);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_flags      <= 4'b0000;
         r_pend       <= '0;
         r_ex_valid   <= 1'b0;
         r_ex_execute <= 1'b0;
         r_ex_tag     <= '0;
         r_pend_err   <= 1'b0;
      end else begin
         r_flags <= w_flags_next;
         r_pend  <= w_pend_next;
         if (i_wb_flags_valid && (r_pend == '0)) begin
            r_pend_err <= 1'b1;
         end
         if (w_accept) begin
            r_ex_valid   <= 1'b1;
            r_ex_execute <= w_cond_ok;
            r_ex_tag     <= i_in_tag;
         end else if (i_ex_ready) begin
            r_ex_valid <= 1'b0;
         end
      end
   end

   assign o_ex_valid   = r_ex_valid;
   assign o_ex_execute = r_ex_execute;
   assign o_ex_tag     = r_ex_tag;
   assign o_flags      = r_flags;
   assign o_pend_err   = r_pend_err;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Scoreboard bench for cond_issue_ctrl: driver pushes expected decisions, a
// negedge monitor pops them whenever the execute-stage handshake completes.
module tb_cond_issue_ctrl;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_cond;
   logic       in_set_flags;
   logic [3:0] in_tag;
   logic       ex_valid;
   logic       ex_ready;
   logic       ex_execute;
   logic [3:0] ex_tag;
   logic       wb_flags_valid;
   logic [3:0] wb_flags;
   logic       sr_wr_en;
   logic [3:0] sr_wr_data;
   logic [3:0] flags;
   logic       pend_err;

   int         n_cmp = 0;
   int         n_mis = 0;
   logic [4:0] sb_q[$];

   cond_issue_ctrl #(.TAG_W(4), .MAX_PEND(3)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_in_valid       (in_valid),
      .o_in_ready       (in_ready),
      .i_in_cond        (in_cond),
      .i_in_set_flags   (in_set_flags),
      .i_in_tag         (in_tag),
      .o_ex_valid       (ex_valid),
      .i_ex_ready       (ex_ready),
      .o_ex_execute     (ex_execute),
      .o_ex_tag         (ex_tag),
      .i_wb_flags_valid (wb_flags_valid),
      .i_wb_flags       (wb_flags),
      .i_sr_wr_en       (sr_wr_en),
      .i_sr_wr_data     (sr_wr_data),
      .o_flags          (flags),
      .o_pend_err       (pend_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: even codes are base conditions, odd codes are their inverse.
   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic z, cf, n, v, base;
      z = f[3]; cf = f[2]; n = f[1]; v = f[0];
      if (c[3:1] == 3'd0)      base = z;
      else if (c[3:1] == 3'd1) base = cf;
      else if (c[3:1] == 3'd2) base = n;
      else if (c[3:1] == 3'd3) base = v;
      else if (c[3:1] == 3'd4) base = cf && !z;
      else if (c[3:1] == 3'd5) base = (n == v);
      else if (c[3:1] == 3'd6) base = !z && (n == v);
      else                     base = 1'b1;
      return c[0] ? !base : base;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input logic [3:0] c, input logic sf, input logic [3:0] tag,
                        input logic exp);
      bit done;
      done         = 1'b0;
      in_valid     = 1'b1;
      in_cond      = c;
      in_set_flags = sf;
      in_tag       = tag;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back({tag, exp});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("issue_accept_in_budget", 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ex_valid && ex_ready) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_mis++;
            $display("FAIL ex_out_unexpected: got tag=%0h exec=%0b expected none",
                     ex_tag, ex_execute);
         end else begin
            logic [4:0] e;
            e = sb_q.pop_front();
            if ({ex_tag, ex_execute} !== e) begin
               n_mis++;
               $display("FAIL ex_out: got tag=%0h exec=%0b expected tag=%0h exec=%0b",
                        ex_tag, ex_execute, e[4:1], e[0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_cond = 4'd0; in_set_flags = 1'b0; in_tag = 4'd0;
      ex_ready = 1'b1; wb_flags_valid = 1'b0; wb_flags = 4'd0;
      sr_wr_en = 1'b0; sr_wr_data = 4'd0;
      idle(2);
      @(negedge clk);
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_ex_execute", 32'(ex_execute), 32'd0);
      check("rst_ex_tag", 32'(ex_tag), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_pend_err", 32'(pend_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // EQ with Z=0 annuls; after MSR Z=1 it executes.
      issue(4'd0, 1'b0, 4'h1, 1'b0);
      sr_wr_en = 1'b1; sr_wr_data = 4'b1000;
      idle(1);
      sr_wr_en = 1'b0;
      @(negedge clk);
      check("msr_flags", 32'(flags), 32'h8);
      @(posedge clk); #1;
      issue(4'd0, 1'b0, 4'h2, 1'b1);

      // Full sweep; sr write is visible to the same-cycle evaluation.
      sr_wr_en = 1'b1;
      for (int f = 0; f < 16; f++) begin
         sr_wr_data = 4'(f);
         for (int c = 0; c < 16; c++) begin
            issue(4'(c), 1'b0, 4'(c), cond_ref(4'(c), 4'(f)));
         end
      end
      sr_wr_data = 4'b1100;
      issue(4'd9, 1'b0, 4'h9, 1'b1);
      issue(4'd8, 1'b0, 4'h8, 1'b0);
      sr_wr_data = 4'b1011;
      issue(4'd13, 1'b0, 4'hD, 1'b1);
      issue(4'd12, 1'b0, 4'hC, 1'b0);
      sr_wr_en = 1'b0;
      idle(1);
      @(negedge clk);
      check("sweep_flags", 32'(flags), 32'hB);
      @(posedge clk); #1;

      // Bypass: NE waits on one flag setter, accepted in the writeback cycle.
      issue(4'd14, 1'b1, 4'h1, 1'b1);
      in_valid = 1'b1; in_cond = 4'd1; in_set_flags = 1'b0; in_tag = 4'h2;
      repeat (2) begin
         @(negedge clk);
         check("ne_stalled", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      wb_flags_valid = 1'b1; wb_flags = 4'b0000;
      @(negedge clk);
      check("ne_bypass_ready", 32'(in_ready), 32'd1);
      if (in_ready) sb_q.push_back({4'h2, 1'b1});
      @(posedge clk); #1;
      in_valid = 1'b0; wb_flags_valid = 1'b0;
      @(negedge clk);
      check("bypass_flags", 32'(flags), 32'h0);
      @(posedge clk); #1;

      // Pending limit with same-cycle writeback relief.
      issue(4'd14, 1'b1, 4'h8, 1'b1);
      issue(4'd14, 1'b1, 4'h9, 1'b1);
      issue(4'd14, 1'b1, 4'hA, 1'b1);
      in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_tag = 4'hB;
      @(negedge clk);
      check("pend_full_stall", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      wb_flags_valid = 1'b1; wb_flags = 4'b0100;
      @(negedge clk);
      check("pend_full_relief", 32'(in_ready), 32'd1);
      if (in_ready) sb_q.push_back({4'hB, 1'b1});
      @(posedge clk); #1;
      wb_flags_valid = 1'b0; in_tag = 4'hC;
      @(negedge clk);
      check("pend_still_full", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_set_flags = 1'b0;
      wb_flags_valid = 1'b1;
      idle(3);
      wb_flags_valid = 1'b0; in_cond = 4'd0;
      @(negedge clk);
      check("drain_no_err", 32'(pend_err), 32'd0);
      check("drain_cond_ready", 32'(in_ready), 32'd1);
      check("drain_flags", 32'(flags), 32'h4);
      @(posedge clk); #1;

      // Output hold under back-pressure.
      ex_ready = 1'b0;
      in_valid = 1'b1; in_cond = 4'd14; in_set_flags = 1'b0; in_tag = 4'hA;
      @(negedge clk);
      check("hold_first_ready", 32'(in_ready), 32'd1);
      if (in_ready) sb_q.push_back({4'hA, 1'b1});
      @(posedge clk); #1;
      in_cond = 4'd15; in_tag = 4'hB;
      repeat (3) begin
         @(negedge clk);
         check("hold_valid", 32'(ex_valid), 32'd1);
         check("hold_tag", 32'(ex_tag), 32'hA);
         check("hold_exec", 32'(ex_execute), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      ex_ready = 1'b1;
      @(negedge clk);
      check("release_ready", 32'(in_ready), 32'd1);
      if (in_ready) sb_q.push_back({4'hB, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      idle(1);
      @(negedge clk);
      check("release_no_dup", 32'(ex_valid), 32'd0);
      @(posedge clk); #1;

      // Writeback with nothing pending; then MSR beats same-cycle writeback.
      wb_flags_valid = 1'b1; wb_flags = 4'b0110;
      idle(1);
      wb_flags_valid = 1'b0;
      @(negedge clk);
      check("err_set", 32'(pend_err), 32'd1);
      check("err_flags", 32'(flags), 32'h6);
      @(posedge clk); #1;
      sr_wr_en = 1'b1; sr_wr_data = 4'b1001;
      wb_flags_valid = 1'b1; wb_flags = 4'b0011;
      idle(1);
      sr_wr_en = 1'b0; wb_flags_valid = 1'b0;
      @(negedge clk);
      check("msr_wins", 32'(flags), 32'h9);
      check("err_sticky", 32'(pend_err), 32'd1);
      @(posedge clk); #1;

      // Reset in the middle of a stall with a held output.
      issue(4'd14, 1'b1, 4'h3, 1'b1);
      @(negedge clk);
      @(posedge clk); #1;
      ex_ready = 1'b0;
      issue(4'd14, 1'b0, 4'h4, 1'b1);
      in_valid = 1'b1; in_cond = 4'd1; in_tag = 4'h5;
      @(negedge clk);
      check("pre_rst_stall", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; in_cond = 4'd14; in_set_flags = 1'b1; in_tag = 4'h6;
      @(posedge clk); #1;
      sb_q.delete();
      @(negedge clk);
      check("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
      check("mid_rst_ex_tag", 32'(ex_tag), 32'd0);
      check("mid_rst_ex_exec", 32'(ex_execute), 32'd0);
      check("mid_rst_flags", 32'(flags), 32'd0);
      check("mid_rst_pend_err", 32'(pend_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; in_set_flags = 1'b0; in_cond = 4'd0; ex_ready = 1'b1;
      @(negedge clk);
      check("after_rst_ready", 32'(in_ready), 32'd1);
      check("after_rst_nothing", 32'(ex_valid), 32'd0);
      @(posedge clk); #1;

      idle(3);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
